// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared fetch-stage types and constants.
//   state_t     : fetch FSM states (IDLE, RUN, HALTED)
//   INSTR_BYTES : bytes per instruction word, used as the sequential PC step
//   NOP         : encoding loaded into the fetch register on reset
package fetch_pc_unit_pkg;
   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
   localparam int INSTR_BYTES = 4;
   localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: fetch-stage bus joining imem, redirect/halt sources and decode.
//   master : fetch unit (drives pc, if_valid, if_instr, if_pc[, misalign_err])
//   slave  : environment (drives inscode, redirect_*, halt, if_ready)
//   FETCH_ALIGN_CHECK_EN adds misalign_err.
interface fetch_pc_unit_if;
   logic [31:0] pc;
   logic [31:0] inscode;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalign_err;
   modport master (output pc, if_valid, if_instr, if_pc, misalign_err,
                   input inscode, redirect_valid, redirect_pc, halt, if_ready);
   modport slave  (input pc, if_valid, if_instr, if_pc, misalign_err,
                   output inscode, redirect_valid, redirect_pc, halt, if_ready);
`else
   modport master (output pc, if_valid, if_instr, if_pc,
                   input inscode, redirect_valid, redirect_pc, halt, if_ready);
   modport slave  (input pc, if_valid, if_instr, if_pc,
                   output inscode, redirect_valid, redirect_pc, halt, if_ready);
`endif
endinterface

// File: rtl/fetch_pc_unit_fetch_reg_slot.sv
// fetch_reg_slot: single-entry valid/ready pipeline register holding instr+pc.
//   clk, rst_n       : clock, async active-low reset
//   i_load           : capture i_instr/i_pc this edge (caller checks o_free)
//   i_flush          : drop the held entry, overrides load and ready
//   i_ready          : downstream consumes the entry this cycle
//   o_valid/o_instr/o_pc : held entry;  o_free : slot can take a new entry
module fetch_reg_slot
   import fetch_pc_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_flush,
   input  logic        i_ready,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc,
   output logic        o_valid,
   output logic        o_free,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc
);
   logic        r_valid;
   logic [31:0] r_instr;
   logic [31:0] r_pc;
   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;
   assign o_free  = !r_valid || i_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_instr <= NOP;
         r_pc    <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC owner and fetch FSM feeding a one-entry fetch register.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_pc_unit_if.master (pc/inscode to imem, redirect/halt in,
//                if_valid/if_ready/if_instr/if_pc to decode)
//   Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirects raise
//   misalign_err and halt instead of silently truncating.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_BYTES = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   fetch_pc_unit_if.master  bus
);
   localparam logic [31:0] MASK = 32'(IMEM_BYTES - 1);
   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt, w_target;
   logic        w_load, w_flush, w_free;
   // Word-align first, then fold into the image so oversize targets wrap.
   assign w_target = bus.redirect_pc & ~32'h3 & MASK;
   assign bus.pc   = r_pc;
`ifdef FETCH_ALIGN_CHECK_EN
   logic r_err, w_err_nxt;
   assign bus.misalign_err = r_err;
`endif
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_load      = 1'b0;
      w_flush     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      w_err_nxt   = r_err;
`endif
      if (bus.redirect_valid) begin
         w_flush     = 1'b1;
         w_pc_nxt    = w_target;
         w_state_nxt = RUN;
`ifdef FETCH_ALIGN_CHECK_EN
         w_err_nxt   = bus.redirect_pc[1:0] != 2'b00;
         if (w_err_nxt) w_state_nxt = HALTED;
`endif
      end else if (r_state == IDLE) begin
         w_state_nxt = RUN;
      end else if (r_state == RUN) begin
         if (bus.halt) begin
            w_state_nxt = HALTED;
         end else if (w_free) begin
            w_load   = 1'b1;
            w_pc_nxt = (r_pc + 32'(INSTR_BYTES)) & MASK;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
         r_err   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
`ifdef FETCH_ALIGN_CHECK_EN
         r_err   <= w_err_nxt;
`endif
      end
   end
   fetch_reg_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_flush (w_flush),
      .i_ready (bus.if_ready),
      .i_instr (bus.inscode),
      .i_pc    (r_pc),
      .o_valid (bus.if_valid),
      .o_free  (w_free),
      .o_instr (bus.if_instr),
      .o_pc    (bus.if_pc)
   );
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed self-checking bench for fetch_pc_unit (32-byte image).
module tb_fetch_pc_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   fetch_pc_unit_if bus ();
   fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_BYTES(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   logic [31:0] mem [8];
   assign bus.inscode = mem[bus.pc[4:2]];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic out(input string tag, input logic v, input logic [31:0] ipc, input logic [31:0] ins, input logic [31:0] p);
      check({tag, ".valid"}, 32'(bus.if_valid), 32'(v));
      if (v) begin
         check({tag, ".if_pc"}, bus.if_pc, ipc);
         check({tag, ".if_instr"}, bus.if_instr, ins);
      end
      check({tag, ".pc"}, bus.pc, p);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end
   initial begin
      mem = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
              32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.halt           = 1'b0;
      bus.if_ready       = 1'b1;
      #12;
      check("rst.pc", bus.pc, 32'h0);
      check("rst.valid", 32'(bus.if_valid), 32'h0);
      check("rst.instr", bus.if_instr, 32'h0);
      check("rst.if_pc", bus.if_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
      check("rst.err", 32'(bus.misalign_err), 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      out("edge1", 1'b0, 0, 0, 32'h0);
      tick();
      for (int k = 0; k < 10; k++) begin
         out($sformatf("stream%0d", k), 1'b1, (4 * k) % 32, 32'h11111111 * (k % 8 + 1), (4 * k + 4) % 32);
         tick();
      end
      out("at8", 1'b1, 32'h8, 32'h33333333, 32'hc);
      bus.if_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         out($sformatf("stall%0d", k), 1'b1, 32'h8, 32'h33333333, 32'hc);
      end
      bus.if_ready = 1'b1;
      tick();
      out("unstall", 1'b1, 32'hc, 32'h44444444, 32'h10);
      for (int k = 0; k < 6; k++) tick();
      out("at4", 1'b1, 32'h4, 32'h22222222, 32'h8);
      bus.if_ready = 1'b0;
      tick();
      out("stall4", 1'b1, 32'h4, 32'h22222222, 32'h8);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h14;
      tick();
      bus.redirect_valid = 1'b0;
      out("redir.flush", 1'b0, 0, 0, 32'h14);
      tick();
      out("redir.tgt", 1'b1, 32'h14, 32'h66666666, 32'h18);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8;
      tick();
      bus.redirect_valid = 1'b0;
      tick();
      out("pre_halt", 1'b1, 32'h8, 32'h33333333, 32'hc);
      bus.if_ready = 1'b1;
      bus.halt     = 1'b1;
      tick();
      bus.halt = 1'b0;
      out("halt0", 1'b0, 0, 0, 32'hc);
      tick();
      out("halt1", 1'b0, 0, 0, 32'hc);
      bus.halt = 1'b1;
      tick();
      bus.halt = 1'b0;
      out("halt2", 1'b0, 0, 0, 32'hc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      tick();
      bus.redirect_valid = 1'b0;
      out("resume.flush", 1'b0, 0, 0, 32'h0);
      tick();
      out("resume", 1'b1, 32'h0, 32'h11111111, 32'h4);
      bus.halt           = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h10;
      tick();
      bus.halt           = 1'b0;
      bus.redirect_valid = 1'b0;
      out("both.flush", 1'b0, 0, 0, 32'h10);
      tick();
      out("both0", 1'b1, 32'h10, 32'h55555555, 32'h14);
      tick();
      out("both1", 1'b1, 32'h14, 32'h66666666, 32'h18);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h26;
      tick();
      bus.redirect_valid = 1'b0;
      check("mask.pc", bus.pc, 32'h4);
`ifdef FETCH_ALIGN_CHECK_EN
      check("mis.err", 32'(bus.misalign_err), 32'h1);
      tick();
      out("mis.halted", 1'b0, 0, 0, 32'h4);
`else
      tick();
      out("mask.tgt", 1'b1, 32'h4, 32'h22222222, 32'h8);
`endif
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h8;
      tick();
      bus.redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      check("mis.clear", 32'(bus.misalign_err), 32'h0);
`endif
      tick();
      out("r8", 1'b1, 32'h8, 32'h33333333, 32'hc);
      tick();
      tick();
      out("at16", 1'b1, 32'h10, 32'h55555555, 32'h14);
      #2 rst_n = 1'b0;
      #1;
      out("arst", 1'b0, 0, 0, 32'h0);
      check("arst.instr", bus.if_instr, 32'h0);
      check("arst.if_pc", bus.if_pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      out("re.edge1", 1'b0, 0, 0, 32'h0);
      tick();
      out("re.edge2", 1'b1, 32'h0, 32'h11111111, 32'h4);
      tick();
      out("re.edge3", 1'b1, 32'h4, 32'h22222222, 32'h8);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
